// File: rtl/jump_field_encoder.sv
// Encodes a 32-bit jump target into the 26-bit sign-extended jump field and
// flags targets that cannot be reproduced by sign-extension. Keeps delivery stats.
module jump_field_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [25:0]      imm26,
   output logic             out_of_range,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      StIdle,
      StCheck,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      cap_q, cap_d;
   logic [25:0]      imm_q, imm_d;
   logic             oor_q, oor_d;
   logic [CNT_W-1:0] enc_q, enc_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             top_uniform;

   // Representable iff bits 31:25 are a pure sign extension of bit 25.
   assign top_uniform = (&cap_q[31:25]) | ~(|cap_q[31:25]);

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      imm_d   = imm_q;
      oor_d   = oor_q;
      enc_d   = enc_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               cap_d   = target;
               state_d = StCheck;
            end
         end
         StCheck: begin
            imm_d   = cap_q[25:0];
            oor_d   = ~top_uniform;
            state_d = StDone;
         end
         StDone: begin
            if (out_ready) begin
               if (enc_q != '1) enc_d = enc_q + CNT_W'(1);
               if (oor_q && (err_q != '1)) err_d = err_q + CNT_W'(1);
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cap_q   <= '0;
         imm_q   <= '0;
         oor_q   <= 1'b0;
         enc_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         imm_q   <= imm_d;
         oor_q   <= oor_d;
         enc_q   <= enc_d;
         err_q   <= err_d;
      end
   end

   // in_ready is gated by reset_n so it drops the moment reset asserts.
   assign in_ready     = reset_n & (state_q == StIdle);
   assign out_valid    = (state_q == StDone);
   assign imm26        = imm_q;
   assign out_of_range = oor_q;
   assign enc_count    = enc_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_jump_field_encoder.sv
// Directed and random bench for jump_field_encoder; a second CNT_W=4 instance
// exercises counter saturation.
module tb_jump_field_encoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, out_ready, in_ready, out_valid, out_of_range;
   logic [31:0] target;
   logic [25:0] imm26;
   logic [15:0] enc_count, err_count;

   logic        in_valid4, out_ready4, in_ready4, out_valid4, oor4;
   logic [31:0] target4;
   logic [25:0] imm4;
   logic [3:0]  enc4, err4;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_enc = 0;
   int exp_err = 0;

   always #5 clk = ~clk;

   jump_field_encoder #(.CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .target(target), .out_valid(out_valid), .out_ready(out_ready), .imm26(imm26),
      .out_of_range(out_of_range), .enc_count(enc_count), .err_count(err_count)
   );

   jump_field_encoder #(.CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .target(target4), .out_valid(out_valid4), .out_ready(out_ready4), .imm26(imm4),
      .out_of_range(oor4), .enc_count(enc4), .err_count(err4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; target = '0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; target4 = '0;
      #3;
      n_cmp++;
      if ({in_ready, out_valid, imm26, out_of_range, enc_count, err_count} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b imm=%h oor=%b enc=%0d err=%0d, want all 0",
                  in_ready, out_valid, imm26, out_of_range, enc_count, err_count);
      end
      @(posedge clk); @(posedge clk); #4;
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1; in_valid = 1'b1; target = 32'h0000_1234;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_check_state: got vld=%b rdy=%b, want 0 0", out_valid, in_ready);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || imm26 !== 26'h000_1234 || out_of_range !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_result: got vld=%b imm=%h oor=%b, want 1 0001234 0",
                  out_valid, imm26, out_of_range);
      end
      step();
      exp_enc++;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_count !== 16'(exp_enc)
          || imm26 !== 26'h000_1234) begin
         n_bad++;
         $display("FAIL basic_after: got vld=%b rdy=%b enc=%0d imm=%h, want 0 1 %0d 0001234",
                  out_valid, in_ready, enc_count, imm26, exp_enc);
      end
   endtask

   task automatic test_boundary();
      logic [31:0] tv [4] = '{32'h01FF_FFFF, 32'hFE00_0000, 32'h0200_0000, 32'hFDFF_FFFF};
      logic [25:0] iv [4] = '{26'h1FF_FFFF, 26'h200_0000, 26'h200_0000, 26'h1FF_FFFF};
      logic        fv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; target = tv[i];
         step();
         in_valid = 1'b0;
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || imm26 !== iv[i] || out_of_range !== fv[i]) begin
            n_bad++;
            $display("FAIL boundary_%0d: target=%h got vld=%b imm=%h oor=%b, want 1 %h %b",
                     i, tv[i], out_valid, imm26, out_of_range, iv[i], fv[i]);
         end
         step();
         exp_enc++;
         if (fv[i]) exp_err++;
      end
      n_cmp++;
      if (enc_count !== 16'(exp_enc) || err_count !== 16'(exp_err)) begin
         n_bad++;
         $display("FAIL boundary_counts: got enc=%0d err=%0d, want %0d %0d",
                  enc_count, err_count, exp_enc, exp_err);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0; in_valid = 1'b1; target = 32'h0ABC_DEF0;
      step();
      step();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; target = 32'h0000_0100 + 32'(i);
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || imm26 !== 26'h2BC_DEF0
             || out_of_range !== 1'b1 || enc_count !== 16'(exp_enc)) begin
            n_bad++;
            $display("FAIL stall_%0d: got vld=%b rdy=%b imm=%h oor=%b enc=%0d, want 1 0 2bcdef0 1 %0d",
                     i, out_valid, in_ready, imm26, out_of_range, enc_count, exp_enc);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      exp_enc++; exp_err++;
      n_cmp++;
      if (out_valid !== 1'b0 || enc_count !== 16'(exp_enc) || err_count !== 16'(exp_err)) begin
         n_bad++;
         $display("FAIL stall_release: got vld=%b enc=%0d err=%0d, want 0 %0d %0d",
                  out_valid, enc_count, err_count, exp_enc, exp_err);
      end
      step(); step();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_count !== 16'(exp_enc)
          || imm26 !== 26'h2BC_DEF0) begin
         n_bad++;
         $display("FAIL idle_out_ready: got vld=%b rdy=%b enc=%0d imm=%h, want 0 1 %0d 2bcdef0",
                  out_valid, in_ready, enc_count, imm26, exp_enc);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1; in_valid = 1'b1; target = 32'hFFFF_FFFF;
      step();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      exp_enc = 0; exp_err = 0;
      n_cmp++;
      if ({in_ready, out_valid, imm26, out_of_range, enc_count, err_count} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: got rdy=%b vld=%b imm=%h oor=%b enc=%0d err=%0d, want all 0",
                  in_ready, out_valid, imm26, out_of_range, enc_count, err_count);
      end
      #2 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_after_%0d: got vld=%b rdy=%b enc=%0d, want 0 1 0",
                     i, out_valid, in_ready, enc_count);
         end
      end
   endtask

   task automatic test_saturate();
      out_ready4 = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid4 = 1'b1; target4 = 32'h4000_0000 + 32'(i);
         step();
         in_valid4 = 1'b0;
         step();
         step();
      end
      n_cmp++;
      if (enc4 !== 4'hF || err4 !== 4'hF) begin
         n_bad++;
         $display("FAIL saturate: got enc=%h err=%h, want f f", enc4, err4);
      end
   endtask

   task automatic test_random();
      logic [31:0] t;
      logic        exp_oor;
      out_ready = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         t = $urandom();
         if (i % 4 == 0) t[31:25] = t[25] ? 7'h7F : 7'h00;
         exp_oor = !(t[31:25] == 7'h00 || t[31:25] == 7'h7F);
         in_valid = 1'b1; target = t;
         step();
         in_valid = 1'b0;
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || imm26 !== t[25:0] || out_of_range !== exp_oor
             || (!exp_oor && {{6{imm26[25]}}, imm26} !== t)) begin
            n_bad++;
            $display("FAIL random_%0d: target=%h got vld=%b imm=%h oor=%b, want 1 %h %b",
                     i, t, out_valid, imm26, out_of_range, t[25:0], exp_oor);
         end
         step();
         exp_enc++;
         if (exp_oor) exp_err++;
      end
      n_cmp++;
      if (enc_count !== 16'(exp_enc) || err_count !== 16'(exp_err)) begin
         n_bad++;
         $display("FAIL random_counts: got enc=%0d err=%0d, want %0d %0d",
                  enc_count, err_count, exp_enc, exp_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_stall();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
